// File: rtl/led_bit_encoder.sv
// Single-wire LED pixel serializer: 24-bit words in over valid/ready,
// pulse-width-coded bits out MSB-first, with a low latch period between frames.
module led_bit_encoder #(
    parameter int BIT_CYCLES   = 62,
    parameter int T0H_CYCLES   = 20,
    parameter int T1H_CYCLES   = 40,
    parameter int RESET_CYCLES = 2500
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [23:0] i_pixel_data,
    input  logic        i_pixel_valid,
    output logic        o_pixel_ready,
    output logic        o_dout,
    output logic        o_busy,
    output logic        o_frame_done
);

    localparam int SW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int LW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    localparam logic [SW-1:0] SLOT_LAST = SW'(BIT_CYCLES - 1);
    localparam logic [SW-1:0] T0H       = SW'(T0H_CYCLES);
    localparam logic [SW-1:0] T1H       = SW'(T1H_CYCLES);
    localparam logic [LW-1:0] LAT_LAST  = LW'(RESET_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        LATCH
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [23:0]   buf_q;
    logic          buf_full;
    logic [23:0]   shreg;
    logic [4:0]    bit_idx;
    logic [SW-1:0] slot;
    logic [LW-1:0] lat;
    logic          pend;

    logic          accept;
    logic          slot_last;
    logic          lat_last;
    logic          load;
    logic          shift;
    logic          pend_nxt;
    logic          dout_nxt;
    logic          done_nxt;

    assign accept        = i_pixel_valid && !buf_full;
    assign slot_last     = (slot == SLOT_LAST);
    assign lat_last      = (lat == LAT_LAST);
    assign o_pixel_ready = !buf_full;
    assign o_busy        = (state != IDLE);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A word arriving mid-latch moves straight into the idle shift
    // register (pend) so the holding buffer can reopen immediately.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift     = 1'b0;
        dout_nxt  = 1'b0;
        done_nxt  = 1'b0;
        pend_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (buf_full) begin
                    load      = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                dout_nxt = (slot < (shreg[23] ? T1H : T0H));
                if (slot_last) begin
                    if (bit_idx != 5'd0) begin
                        shift = 1'b1;
                    end else if (buf_full) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = LATCH;
                    end
                end
            end
            LATCH: begin
                if (lat_last) begin
                    done_nxt = 1'b1;
                    if (pend) begin
                        state_nxt = SEND;
                    end else if (buf_full) begin
                        load      = 1'b1;
                        state_nxt = SEND;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    pend_nxt = pend;
                    if (buf_full && !pend) begin
                        load     = 1'b1;
                        pend_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            buf_q    <= '0;
            buf_full <= 1'b0;
        end else if (accept) begin
            buf_q    <= i_pixel_data;
            buf_full <= 1'b1;
        end else if (load) begin
            buf_full <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            shreg   <= '0;
            bit_idx <= '0;
        end else if (load) begin
            shreg   <= buf_q;
            bit_idx <= 5'd23;
        end else if (shift) begin
            shreg   <= {shreg[22:0], 1'b0};
            bit_idx <= bit_idx - 5'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            slot <= '0;
            lat  <= '0;
            pend <= 1'b0;
        end else begin
            slot <= (state == SEND && !slot_last) ? slot + 1'b1 : '0;
            lat  <= (state == LATCH && !lat_last) ? lat + 1'b1 : '0;
            pend <= pend_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_dout       <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            o_dout       <= dout_nxt;
            o_frame_done <= done_nxt;
        end
    end

endmodule

// File: tb/tb_led_bit_encoder.sv
// Bench for led_bit_encoder: default build plus a tiny-timing build,
// checked against a word/slot timeline model of the line.
module tb_led_bit_encoder;

    localparam int LOGN = 131072;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  vld;
    logic [1:0]  rdy;
    logic [1:0]  dout;
    logic [1:0]  busy;
    logic [1:0]  done;
    logic [23:0] dat [2];

    int checks = 0;
    int errors = 0;
    int ncyc   = 0;

    logic        lg_dout [2][LOGN];
    logic        lg_rdy  [2][LOGN];
    logic        lg_vld  [2][LOGN];
    logic        lg_done [2][LOGN];
    logic        lg_busy [2][LOGN];
    logic [23:0] lg_dat  [2][LOGN];
    logic        ed [LOGN];
    logic        ef [LOGN];

    always #5 clk = ~clk;

    led_bit_encoder u_dut0 (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_pixel_data  (dat[0]),
        .i_pixel_valid (vld[0]),
        .o_pixel_ready (rdy[0]),
        .o_dout        (dout[0]),
        .o_busy        (busy[0]),
        .o_frame_done  (done[0])
    );

    led_bit_encoder #(
        .BIT_CYCLES   (4),
        .T0H_CYCLES   (1),
        .T1H_CYCLES   (3),
        .RESET_CYCLES (1)
    ) u_dut1 (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_pixel_data  (dat[1]),
        .i_pixel_valid (vld[1]),
        .o_pixel_ready (rdy[1]),
        .o_dout        (dout[1]),
        .o_busy        (busy[1]),
        .o_frame_done  (done[1])
    );

    always @(negedge clk) begin
        if (ncyc < LOGN) begin
            for (int d = 0; d < 2; d++) begin
                lg_dout[d][ncyc] = dout[d];
                lg_rdy[d][ncyc]  = rdy[d];
                lg_vld[d][ncyc]  = vld[d];
                lg_done[d][ncyc] = done[d];
                lg_busy[d][ncyc] = busy[d];
                lg_dat[d][ncyc]  = dat[d];
            end
        end
        ncyc++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_to(input int idx);
        int n = 0;
        while (ncyc < idx && n < 60000) begin
            step(1);
            n++;
        end
    endtask

    // Offer a word and return the sample index seen just before the
    // accepting edge; valid stays high for the caller to drop or reuse.
    task automatic offer(input int d, input logic [23:0] w, output int h);
        int n = 0;
        vld[d] = 1'b1;
        dat[d] = w;
        while (!rdy[d] && n < 20000) begin
            step(1);
            n++;
        end
        h = ncyc;
        checks++;
        assert (rdy[d] === 1'b1) else begin
            errors++;
            vld[d] = 1'b0;
            $error("FAIL offer_timeout dut%0d: ready %b expected 1", d, rdy[d]);
        end
        step(1);
    endtask

    function automatic int first_rise(input int d, input int from, input int to);
        for (int i = from; i < to; i++) begin
            if (lg_dout[d][i] === 1'b1) return i;
        end
        return -1;
    endfunction

    function automatic int count_done(input int d, input int from, input int to);
        int c = 0;
        for (int i = from; i < to; i++) begin
            if (lg_done[d][i] === 1'b1) c++;
        end
        return c;
    endfunction

    function automatic int count_rdy(input int d, input int from, input int to);
        int c = 0;
        for (int i = from; i < to; i++) begin
            if (lg_rdy[d][i] === 1'b1) c++;
        end
        return c;
    endfunction

    // Timeline model: each accepted word gets a start sample, then 24
    // slots of B samples high for T0/T1; a frame ends with R low samples.
    task automatic check_window(input int d, input int from, input int to,
                                input string tag);
        int  bb, t0, t1, rr, e, s, bad_d, bad_f;
        bit  have;
        bb   = (d == 0) ? 62 : 4;
        t0   = (d == 0) ? 20 : 1;
        t1   = (d == 0) ? 40 : 3;
        rr   = (d == 0) ? 2500 : 1;
        e    = -100000;
        have = 1'b0;
        for (int i = from; i < to; i++) begin
            ed[i] = 1'b0;
            ef[i] = 1'b0;
        end
        for (int i = from; i < to; i++) begin
            if (lg_vld[d][i] === 1'b1 && lg_rdy[d][i] === 1'b1) begin
                if (have && i <= e - 3) begin
                    s = e;
                end else begin
                    if (have && e + rr - 1 < to) ef[e + rr - 1] = 1'b1;
                    s = (have && i <= e + rr - 3) ? e + rr : i + 3;
                end
                for (int b = 0; b < 24; b++) begin
                    for (int c = 0; c < bb; c++) begin
                        if (s + b * bb + c < to)
                            ed[s + b * bb + c] =
                                (c < (lg_dat[d][i][23 - b] ? t1 : t0));
                    end
                end
                e    = s + 24 * bb;
                have = 1'b1;
            end
        end
        if (have && e + rr - 1 < to) ef[e + rr - 1] = 1'b1;
        bad_d = -1;
        bad_f = -1;
        for (int i = from; i < to; i++) begin
            if (bad_d < 0 && lg_dout[d][i] !== ed[i]) bad_d = i;
            if (bad_f < 0 && lg_done[d][i] !== ef[i]) bad_f = i;
        end
        checks++;
        assert (bad_d === -1) else begin
            errors++;
            $error("FAIL %s_dout: sample %0d got %b expected %b",
                   tag, bad_d, lg_dout[d][bad_d], ed[bad_d]);
        end
        checks++;
        assert (bad_f === -1) else begin
            errors++;
            $error("FAIL %s_done: sample %0d got %b expected %b",
                   tag, bad_f, lg_done[d][bad_f], ef[bad_f]);
        end
    endtask

    initial begin
        int h, h1, h2, hy, s, e, w0, g;
        rst_n  = 1'b0;
        vld    = 2'b00;
        dat[0] = '0;
        dat[1] = '0;
        step(3);
        for (int d = 0; d < 2; d++) begin
            chk("rst_dout", 32'(dout[d]), 0);
            chk("rst_busy", 32'(busy[d]), 0);
            chk("rst_ready", 32'(rdy[d]), 1);
            chk("rst_done", 32'(done[d]), 0);
        end
        rst_n = 1'b1;
        step(2);

        w0 = ncyc;
        offer(0, 24'hFF00A5, h);
        vld[0] = 1'b0;
        e = h + 3 + 1488;
        wait_to(e + 2500 + 5);
        check_window(0, w0, ncyc, "single");
        chk("single_rise", first_rise(0, h, ncyc), h + 3);
        chk("single_done_cnt", count_done(0, w0, ncyc), 1);
        chk("single_done_at", 32'(lg_done[0][e + 2499]), 1);
        chk("single_busy_hi", 32'(lg_busy[0][e + 2498]), 1);
        chk("single_busy_lo", 32'(lg_busy[0][e + 2499]), 0);

        w0 = ncyc;
        offer(0, 24'h123456, h);
        offer(0, 24'hABCDEF, h1);
        offer(0, 24'h0F0F0F, h2);
        vld[0] = 1'b0;
        wait_to(h + 3 + 4464 + 2500 + 5);
        chk("b2b_h1", h1, h + 2);
        chk("b2b_h2", h2, h + 1490);
        chk("b2b_ready_lo", count_rdy(0, h1 + 1, h2), 0);
        chk("b2b_rise", first_rise(0, h, ncyc), h + 3);
        chk("b2b_done_cnt", count_done(0, w0, ncyc), 1);
        chk("b2b_done_at", 32'(lg_done[0][h + 3 + 4464 + 2499]), 1);
        check_window(0, w0, ncyc, "b2b");

        w0 = ncyc;
        offer(0, 24'h5A3C96, h);
        vld[0] = 1'b0;
        e = h + 3 + 1488;
        wait_to(e + 8);
        offer(0, 24'hC3A501, hy);
        vld[0] = 1'b0;
        wait_to(e + 2500 + 1488 + 2500 + 10);
        chk("latch_hs", hy, e + 8);
        chk("latch_rdy_lo", 32'(lg_rdy[0][hy + 1]), 0);
        chk("latch_rdy_hi", 32'(lg_rdy[0][hy + 2]), 1);
        chk("latch_done_at", 32'(lg_done[0][e + 2499]), 1);
        chk("latch_busy", 32'(lg_busy[0][e + 2499]), 1);
        chk("latch_rise", first_rise(0, e, ncyc), e + 2500);
        chk("latch_done_cnt", count_done(0, w0, ncyc), 2);
        check_window(0, w0, ncyc, "latch");

        offer(0, 24'hFFFFFF, h);
        vld[0] = 1'b0;
        s = h + 3;
        wait_to(s + 18 * 62 + 10);
        #2;
        chk("rst_mid_pre", 32'(dout[0]), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_dout", 32'(dout[0]), 0);
        chk("rst_mid_busy", 32'(busy[0]), 0);
        chk("rst_mid_ready", 32'(rdy[0]), 1);
        chk("rst_mid_done", 32'(done[0]), 0);
        step(2);
        rst_n = 1'b1;
        step(2);
        w0 = ncyc;
        offer(0, 24'h000001, h);
        vld[0] = 1'b0;
        wait_to(h + 3 + 1488 + 2500 + 5);
        chk("rst_new_rise", first_rise(0, w0, ncyc), h + 3);
        chk("rst_new_done", count_done(0, w0, ncyc), 1);
        check_window(0, w0, ncyc, "after_rst");

        w0 = ncyc;
        offer(1, 24'hC00001, h);
        vld[1] = 1'b0;
        wait_to(h + 3 + 96 + 1 + 5);
        chk("tiny_rise", first_rise(1, h, ncyc), h + 3);
        chk("tiny_done_at", 32'(lg_done[1][h + 99]), 1);
        chk("tiny_busy_hi", 32'(lg_busy[1][h + 98]), 1);
        chk("tiny_busy_lo", 32'(lg_busy[1][h + 99]), 0);
        check_window(1, w0, ncyc, "tiny");

        w0 = ncyc;
        for (int n = 0; n < 16; n++) begin
            offer(1, 24'($urandom), h);
            if ($urandom_range(0, 3) != 0) begin
                vld[1] = 1'b0;
                step($urandom_range(1, 110));
            end
        end
        vld[1] = 1'b0;
        wait_to(ncyc + 2 * 96 + 12);
        check_window(1, w0, ncyc, "tiny_rand");

        w0 = ncyc;
        for (int n = 0; n < 4; n++) begin
            offer(0, 24'($urandom), h);
            unique case ($urandom_range(0, 3))
                0: g = 0;
                1: g = $urandom_range(1480, 1495);
                2: g = $urandom_range(1496, 3990);
                default: g = $urandom_range(4000, 4200);
            endcase
            if (g != 0) begin
                vld[0] = 1'b0;
                step(g);
            end
        end
        vld[0] = 1'b0;
        wait_to(ncyc + 2 * 1488 + 2500 + 10);
        check_window(0, w0, ncyc, "rand");

        chk("log_space", 32'(ncyc < LOGN), 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
